rgb_to_gray_pipe: RTL and testbench

RGB_TO_GRAY_PIPE -- requirements
Module: rgb_to_gray_pipe

---
 rtl/rgb_to_gray_pipe_pkg.sv | 30 +++
 rtl/rgb_to_gray_pipe_if.sv | 11 +
 rtl/rgb_to_gray_pipe_frame_max.sv | 49 ++++
 rtl/rgb_to_gray_pipe.sv | 129 ++++++++++++
 tb/tb_rgb_to_gray_pipe.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rgb_to_gray_pipe_pkg.sv
// Shared imaging constants for the RGB-to-gray pipeline: mode encodings,
// luma/average weights and the post-multiply shift for each mode.
package rgb_to_gray_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_AVG4  = 2'd0,
    MODE_AVG3  = 2'd1,
    MODE_LUMA  = 2'd2,
    MODE_GREEN = 2'd3
  } grayModeT;

  localparam int unsigned LUMA_R_W   = 77;
  localparam int unsigned LUMA_G_W   = 150;
  localparam int unsigned LUMA_B_W   = 29;
  localparam int unsigned AVG3_MUL   = 171;
  localparam int unsigned LUMA_SHIFT = 8;
  localparam int unsigned AVG3_SHIFT = 9;
  localparam int unsigned AVG4_SHIFT = 2;

  // Right-shift applied to the wide intermediate value of each mode.
  function automatic int unsigned modeShift(grayModeT mode);
    case (mode)
      MODE_AVG4: modeShift = AVG4_SHIFT;
      MODE_AVG3: modeShift = AVG3_SHIFT;
      MODE_LUMA: modeShift = LUMA_SHIFT;
      default:   modeShift = 0;
    endcase
  endfunction

endpackage

// File: rtl/rgb_to_gray_pipe_if.sv
// Output-side pixel stream of the gray pipeline: result sample plus its
// valid and frame markers, consumed by the frame-max tracker.
interface rgb_to_gray_pipe_if #(parameter int DATA_W = 12);
  logic [DATA_W-1:0] gray;
  logic              dval;
  logic              sof;
  logic              eof;

  modport master (output gray, dval, sof, eof);
  modport slave  (input  gray, dval, sof, eof);
endinterface

// File: rtl/rgb_to_gray_pipe_frame_max.sv
// Tracks the largest gray value of each frame on the output stream and
// publishes it with a one-cycle strobe after the frame's last pixel.
module gray_frame_max
  import rgb_to_gray_pipe_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic               iCLK,
  input  logic               iRST,
  rgb_to_gray_pipe_if.slave  pixIn,
  output logic [DATA_W-1:0]  oFrameMax,
  output logic               oMaxValid
);

  logic [DATA_W-1:0] runMaxReg, runMaxNext;
  logic [DATA_W-1:0] frameMaxReg, frameMaxNext;
  logic              maxValidReg, maxValidNext;

  // A new SOF restarts the running max, so a frame missing its EOF is dropped.
  always_comb begin
    runMaxNext   = runMaxReg;
    frameMaxNext = frameMaxReg;
    maxValidNext = 1'b0;
    if (pixIn.dval) begin
      if (pixIn.sof || (pixIn.gray > runMaxReg))
        runMaxNext = pixIn.gray;
      if (pixIn.eof) begin
        frameMaxNext = runMaxNext;
        maxValidNext = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      runMaxReg   <= '0;
      frameMaxReg <= '0;
      maxValidReg <= 1'b0;
    end else begin
      runMaxReg   <= runMaxNext;
      frameMaxReg <= frameMaxNext;
      maxValidReg <= maxValidNext;
    end
  end

  assign oFrameMax = frameMaxReg;
  assign oMaxValid = maxValidReg;

endmodule

// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB to grayscale converter with per-frame mode latching and
// a per-frame maximum of the produced gray values.
module rgb_to_gray_pipe
  import rgb_to_gray_pipe_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic              iEOF,
  input  logic [1:0]        iMode,
  output logic [DATA_W-1:0] oGray,
  output logic              oDVAL,
  output logic              oSOF,
  output logic              oEOF,
  output logic [DATA_W-1:0] oFrameMax,
  output logic              oMaxValid
);

  localparam int SUM_W  = DATA_W + 2;
  localparam int WIDE_W = DATA_W + 10;

  grayModeT          modeShadowReg, modeShadowNext;
  logic              s1ValidReg, s1SofReg, s1EofReg;
  grayModeT          s1ModeReg;
  logic [DATA_W-1:0] s1RedReg, s1GreenReg, s1BlueReg;
  logic              s2ValidReg, s2SofReg, s2EofReg;
  grayModeT          s2ModeReg;
  logic [WIDE_W-1:0] s2WideReg;
  logic [DATA_W-1:0] grayReg, grayNext;
  logic              dvalReg, sofReg, eofReg;

  logic [SUM_W-1:0]  chanSum;
  logic [WIDE_W-1:0] lumaSum, wideNext, shifted;

  // The SOF pixel itself already uses the freshly requested mode.
  always_comb begin
    modeShadowNext = modeShadowReg;
    if (iDVAL && iSOF)
      modeShadowNext = grayModeT'(iMode);
  end

  always_comb begin
    chanSum  = SUM_W'(s1RedReg) + SUM_W'(s1GreenReg) + SUM_W'(s1BlueReg);
    lumaSum  = WIDE_W'(s1RedReg)   * WIDE_W'(LUMA_R_W)
             + WIDE_W'(s1GreenReg) * WIDE_W'(LUMA_G_W)
             + WIDE_W'(s1BlueReg)  * WIDE_W'(LUMA_B_W);
    wideNext = WIDE_W'(s1GreenReg);
    case (s1ModeReg)
      MODE_AVG4: wideNext = WIDE_W'(chanSum);
      MODE_AVG3: wideNext = WIDE_W'(chanSum) * WIDE_W'(AVG3_MUL);
      MODE_LUMA: wideNext = lumaSum;
      default:   wideNext = WIDE_W'(s1GreenReg);
    endcase
  end

  // Truncating shift, then clamp anything above the sample range.
  always_comb begin
    shifted  = s2WideReg >> modeShift(s2ModeReg);
    grayNext = (|shifted[WIDE_W-1:DATA_W]) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      modeShadowReg <= MODE_AVG4;
      s1ValidReg    <= 1'b0;
      s1SofReg      <= 1'b0;
      s1EofReg      <= 1'b0;
      s1ModeReg     <= MODE_AVG4;
      s1RedReg      <= '0;
      s1GreenReg    <= '0;
      s1BlueReg     <= '0;
      s2ValidReg    <= 1'b0;
      s2SofReg      <= 1'b0;
      s2EofReg      <= 1'b0;
      s2ModeReg     <= MODE_AVG4;
      s2WideReg     <= '0;
      grayReg       <= '0;
      dvalReg       <= 1'b0;
      sofReg        <= 1'b0;
      eofReg        <= 1'b0;
    end else begin
      modeShadowReg <= modeShadowNext;
      s1ValidReg    <= iDVAL;
      s1SofReg      <= iDVAL & iSOF;
      s1EofReg      <= iDVAL & iEOF;
      s1ModeReg     <= modeShadowNext;
      s1RedReg      <= iRed;
      s1GreenReg    <= iGreen;
      s1BlueReg     <= iBlue;
      s2ValidReg    <= s1ValidReg;
      s2SofReg      <= s1SofReg;
      s2EofReg      <= s1EofReg;
      s2ModeReg     <= s1ModeReg;
      s2WideReg     <= wideNext;
      if (s2ValidReg)
        grayReg <= grayNext;
      dvalReg       <= s2ValidReg;
      sofReg        <= s2SofReg;
      eofReg        <= s2EofReg;
    end
  end

  rgb_to_gray_pipe_if #(.DATA_W(DATA_W)) pixOut ();

  assign pixOut.gray = grayReg;
  assign pixOut.dval = dvalReg;
  assign pixOut.sof  = sofReg;
  assign pixOut.eof  = eofReg;

  gray_frame_max #(.DATA_W(DATA_W)) frameMax (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .pixIn     (pixOut),
    .oFrameMax (oFrameMax),
    .oMaxValid (oMaxValid)
  );

  assign oGray = grayReg;
  assign oDVAL = dvalReg;
  assign oSOF  = sofReg;
  assign oEOF  = eofReg;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Directed-vector bench for rgb_to_gray_pipe: every cycle's outputs are logged,
// then compared against hand-computed values at the expected latency.
module tb_rgb_to_gray_pipe;

  localparam int DW = 12;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic          iDVAL = 1'b0, iSOF = 1'b0, iEOF = 1'b0;
  logic [1:0]    iMode = 2'd0;
  logic [DW-1:0] oGray, oFrameMax;
  logic          oDVAL, oSOF, oEOF, oMaxValid;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;

  logic [DW-1:0] lgGray [0:255];
  logic [DW-1:0] lgMax  [0:255];
  logic          lgDval [0:255];
  logic          lgSof  [0:255];
  logic          lgEof  [0:255];
  logic          lgMv   [0:255];

  always #5 iCLK = ~iCLK;

  rgb_to_gray_pipe_if #(.DATA_W(DW)) mon ();
  assign mon.gray = oGray;
  assign mon.dval = oDVAL;
  assign mon.sof  = oSOF;
  assign mon.eof  = oEOF;

  rgb_to_gray_pipe #(.DATA_W(DW)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iRed      (iRed),
    .iGreen    (iGreen),
    .iBlue     (iBlue),
    .iDVAL     (iDVAL),
    .iSOF      (iSOF),
    .iEOF      (iEOF),
    .iMode     (iMode),
    .oGray     (oGray),
    .oDVAL     (oDVAL),
    .oSOF      (oSOF),
    .oEOF      (oEOF),
    .oFrameMax (oFrameMax),
    .oMaxValid (oMaxValid)
  );

  task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
    lgGray[cyc] = mon.gray;
    lgDval[cyc] = mon.dval;
    lgSof[cyc]  = mon.sof;
    lgEof[cyc]  = mon.eof;
    lgMax[cyc]  = oFrameMax;
    lgMv[cyc]   = oMaxValid;
  endtask

  // Drives one input cycle; idx is the log slot of the edge that sampled it.
  task automatic pix(input int r, input int g, input int b, input bit dv, input bit sof,
                     input bit eof, input int mode, output int idx);
    iRed   = r[DW-1:0];
    iGreen = g[DW-1:0];
    iBlue  = b[DW-1:0];
    iDVAL  = dv;
    iSOF   = sof;
    iEOF   = eof;
    iMode  = mode[1:0];
    step();
    idx = cyc;
    $display("[TB] cyc %0d pix rgb=(%0d,%0d,%0d) dval=%0d sof=%0d eof=%0d mode=%0d",
             idx, r, g, b, dv, sof, eof, mode);
  endtask

  task automatic idle(input int n);
    int tmp;
    for (int i = 0; i < n; i++) pix(0, 0, 0, 1'b0, 1'b0, 1'b0, 0, tmp);
  endtask

  initial begin
    int a, b, c, d, e, f, g, h, k, m, n, p, q, r, s, t, u, v, w, x, y, z;
    int pulses;

    iRST = 1'b1;
    step();
    step();
    checkEq("rst_gray", oGray, 0);
    checkEq("rst_dval", oDVAL, 0);
    checkEq("rst_sof", oSOF, 0);
    checkEq("rst_eof", oEOF, 0);
    checkEq("rst_fmax", oFrameMax, 0);
    checkEq("rst_mv", oMaxValid, 0);
    iRST = 1'b0;

    pix(4095, 4095, 4095, 1, 1, 1, 0, a);
    idle(1);
    pix(300, 300, 300, 1, 1, 0, 1, b);
    pix(4095, 4095, 4095, 1, 0, 1, 1, c);
    pix(4095, 0, 0, 1, 1, 0, 2, d);
    pix(4095, 4095, 4095, 1, 0, 1, 2, e);
    pix(7, 1234, 7, 1, 1, 1, 3, f);
    pix(400, 400, 400, 1, 1, 0, 0, g);
    pix(400, 400, 400, 1, 0, 0, 2, h);
    pix(400, 400, 400, 1, 0, 1, 2, k);
    pix(400, 400, 400, 1, 1, 1, 2, m);
    pix(0, 10, 0, 1, 1, 0, 3, n);
    pix(0, 900, 0, 1, 0, 0, 3, p);
    pix(0, 0, 0, 0, 1, 1, 0, q);
    pix(0, 5, 0, 1, 0, 0, 0, r);
    pix(0, 20, 0, 1, 0, 1, 0, s);
    idle(2);
    pix(0, 50, 0, 1, 1, 0, 3, t);
    pix(0, 30, 0, 1, 1, 0, 3, u);
    pix(0, 20, 0, 1, 0, 1, 3, v);
    idle(3);
    pix(0, 111, 0, 1, 1, 0, 3, w);
    pix(0, 222, 0, 1, 0, 0, 3, x);
    iRST = 1'b1;
    pix(0, 0, 0, 0, 0, 0, 0, y);
    iRST = 1'b0;
    idle(4);
    pix(100, 100, 100, 1, 0, 0, 3, z);
    idle(4);

    checkEq("m0_lat_early", lgDval[a+1], 0);
    checkEq("m0_dval", lgDval[a+2], 1);
    checkEq("m0_gray", lgGray[a+2], 3071);
    checkEq("m0_sof", lgSof[a+2], 1);
    checkEq("m0_eof", lgEof[a+2], 1);
    checkEq("m0_fmax", lgMax[a+3], 3071);
    checkEq("m0_mv", lgMv[a+3], 1);
    checkEq("m0_mv_off", lgMv[a+4], 0);

    checkEq("m1_300", lgGray[b+2], 300);
    checkEq("m1_sat", lgGray[c+2], 4095);
    checkEq("m1_fmax", lgMax[c+3], 4095);

    checkEq("m2_red", lgGray[d+2], 1231);
    checkEq("m2_sat", lgGray[e+2], 4095);
    checkEq("m3_green", lgGray[f+2], 1234);

    checkEq("mid_sof", lgGray[g+2], 300);
    checkEq("mid_chg1", lgGray[h+2], 300);
    checkEq("mid_chg2", lgGray[k+2], 300);
    checkEq("next_sof_m2", lgGray[m+2], 400);

    checkEq("fm_p0", lgGray[n+2], 10);
    checkEq("fm_p1", lgGray[p+2], 900);
    checkEq("bub_dval", lgDval[q+2], 0);
    checkEq("bub_hold", lgGray[q+2], 900);
    checkEq("bub_sof", lgSof[q+2], 0);
    checkEq("bub_eof", lgEof[q+2], 0);
    checkEq("fm_p2", lgGray[r+2], 5);
    checkEq("fm_p3", lgGray[s+2], 20);
    checkEq("fm_mv_early", lgMv[s+2], 0);
    checkEq("fm_mv", lgMv[s+3], 1);
    checkEq("fm_max", lgMax[s+3], 900);
    checkEq("fm_mv_late", lgMv[s+4], 0);
    pulses = 0;
    for (int i = n + 4; i <= s + 6; i++) pulses += int'(lgMv[i]);
    checkEq("fm_pulses", pulses, 1);

    checkEq("noeof_mv", lgMv[u+3], 0);
    checkEq("noeof_fmax", lgMax[v+3], 30);
    checkEq("noeof_mv2", lgMv[v+3], 1);

    checkEq("rstmid_gray", lgGray[y], 0);
    checkEq("rstmid_dval", lgDval[y], 0);
    checkEq("rstmid_fmax", lgMax[y], 0);
    checkEq("rstmid_mv", lgMv[y], 0);
    for (int i = y + 1; i <= y + 4; i++) checkEq("rstmid_stale", lgDval[i], 0);
    checkEq("rstmid_fmax_hold", lgMax[y+4], 0);
    checkEq("post_rst_dval", lgDval[z+2], 1);
    checkEq("post_rst_mode0", lgGray[z+2], 75);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
